// File: rtl/wavetable_pkg.sv
// ---------------------------------------------------------------------------
// wavetable_pkg
// Shared definitions for the wavetable LFO reader: default parameter values
// and the lookup sequencer state encoding.
// ---------------------------------------------------------------------------
package wavetable_pkg;

   localparam int DWIDTH_DEF  = 16;   // sample width (unsigned)
   localparam int AWIDTH_DEF  = 9;    // table address width
   localparam int PHASE_W_DEF = 24;   // phase accumulator width
   localparam int FRAC_W_DEF  = 8;    // interpolation fraction width

   // One state per cycle of a lookup; the tick arrives in IDLE (cycle 0).
   // The second address phase overlaps the first capture, so there is no
   // separate ADDR1 state: CAPT0 is that cycle. DONE is the cycle in which
   // the result pulse is visible, keeping the block busy until it ends.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,   // waiting for tick
      ST_ADDR0 = 3'd1,   // cycle 1: address idx at ROM, present idx+1 next
      ST_CAPT0 = 3'd2,   // cycle 2: capture s0 (ADDR1 merged here)
      ST_CAPT1 = 3'd3,   // cycle 3: capture s1
      ST_MUL   = 3'd4,   // cycle 4: register (s1-s0)*frac
      ST_OUT   = 3'd5,   // cycle 5: register s0 + product/2**FRAC_W
      ST_DONE  = 3'd6    // cycle 6: lfo_valid_o high
   } state_t;

endpackage

// File: rtl/wavetable_reader_lfo_interp.sv
// ---------------------------------------------------------------------------
// lfo_interp
// Two-stage linear interpolation datapath between adjacent table samples.
//   clk_i     : clock
//   srst_i    : synchronous active-high reset
//   mul_en_i  : load the product register (MUL cycle)
//   out_en_i  : load the output register (OUT cycle)
//   s0_i/s1_i : adjacent samples, unsigned, held stable by the parent
//   frac_i    : interpolation fraction, unsigned
//   lfo_o     : interpolated value, held between updates
// ---------------------------------------------------------------------------
module lfo_interp
   import wavetable_pkg::*;
#(
   parameter int DWIDTH = DWIDTH_DEF,
   parameter int FRAC_W = FRAC_W_DEF
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic              mul_en_i,
   input  logic              out_en_i,
   input  logic [DWIDTH-1:0] s0_i,
   input  logic [DWIDTH-1:0] s1_i,
   input  logic [FRAC_W-1:0] frac_i,
   output logic [DWIDTH-1:0] lfo_o
);

   localparam int PW = DWIDTH + 1 + FRAC_W;

   logic signed [DWIDTH:0] w_diff;
   logic signed [PW-1:0]   w_prod;
   logic signed [PW-1:0]   r_prod;
   logic [DWIDTH-1:0]      r_lfo;

   // Signed difference and product; |diff*frac| < 2**(DWIDTH+FRAC_W) so PW bits never overflow
   always_comb begin
      w_diff = $signed({1'b0, s1_i}) - $signed({1'b0, s0_i});
      w_prod = PW'(w_diff) * PW'($signed({1'b0, frac_i}));
   end

   // Pipeline registers: product in MUL, sum in OUT (arithmetic shift floors toward -inf)
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         r_prod <= {PW{1'b0}};
         r_lfo  <= {DWIDTH{1'b0}};
      end else begin
         if (mul_en_i) begin
            r_prod <= w_prod;
         end else begin
            r_prod <= r_prod;
         end
         if (out_en_i) begin
            r_lfo <= s0_i + DWIDTH'(r_prod >>> FRAC_W);
         end else begin
            r_lfo <= r_lfo;
         end
      end
   end

   assign lfo_o = r_lfo;

endmodule

// File: rtl/wavetable_reader.sv
// ---------------------------------------------------------------------------
// wavetable_reader
// Phase-accumulator LFO that reads two adjacent samples from an external
// wavetable ROM (registered address, 1-cycle latency) and linearly
// interpolates between them. One lookup per accepted tick, 6-cycle latency.
//   clk_i        : clock
//   srst_i       : synchronous active-high reset, highest priority
//   tick_i       : sample strobe; ignored (and flagged) while busy
//   phase_inc_i  : phase increment, sampled on an accepted tick only
//   phase_rst_i  : zero the phase accumulator
//   rom_rdaddr_o : registered ROM read address
//   rom_rddata_i : ROM data, one cycle after the address
//   lfo_o        : interpolated output, held between updates
//   lfo_valid_o  : one-cycle pulse when lfo_o updates
//   busy_o       : lookup in progress
//   overrun_o    : sticky, a tick arrived while busy
// ---------------------------------------------------------------------------
module wavetable_reader
   import wavetable_pkg::*;
#(
   parameter int DWIDTH  = DWIDTH_DEF,
   parameter int AWIDTH  = AWIDTH_DEF,
   parameter int PHASE_W = PHASE_W_DEF,
   parameter int FRAC_W  = FRAC_W_DEF
) (
   input  logic               clk_i,
   input  logic               srst_i,
   input  logic               tick_i,
   input  logic [PHASE_W-1:0] phase_inc_i,
   input  logic               phase_rst_i,
   output logic [AWIDTH-1:0]  rom_rdaddr_o,
   input  logic [DWIDTH-1:0]  rom_rddata_i,
   output logic [DWIDTH-1:0]  lfo_o,
   output logic               lfo_valid_o,
   output logic               busy_o,
   output logic               overrun_o
);

   state_t             r_state;
   state_t             w_next_state;
   logic [PHASE_W-1:0] r_phase;
   logic [PHASE_W-1:0] w_lookup_phase;
   logic [AWIDTH-1:0]  r_idx;
   logic [AWIDTH-1:0]  r_rom_addr;
   logic [FRAC_W-1:0]  r_frac;
   logic [DWIDTH-1:0]  r_s0;
   logic [DWIDTH-1:0]  r_s1;
   logic               r_valid;
   logic               r_busy;
   logic               r_overrun;
   logic               w_accept;
   logic               w_load_addr1;
   logic               w_cap0;
   logic               w_cap1;
   logic               w_mul_en;
   logic               w_out_en;
   logic [DWIDTH-1:0]  w_lfo;

   // Phase used by a lookup: a coincident phase sync makes it start from zero
   always_comb begin
      if (phase_rst_i) begin
         w_lookup_phase = {PHASE_W{1'b0}};
      end else begin
         w_lookup_phase = r_phase;
      end
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic: only IDLE waits, every other state advances
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (tick_i) begin
               w_next_state = ST_ADDR0;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_ADDR0: w_next_state = ST_CAPT0;
         ST_CAPT0: w_next_state = ST_CAPT1;
         ST_CAPT1: w_next_state = ST_MUL;
         ST_MUL:   w_next_state = ST_OUT;
         ST_OUT:   w_next_state = ST_DONE;
         ST_DONE:  w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   // Per-state datapath strobes
   always_comb begin
      w_accept     = 1'b0;
      w_load_addr1 = 1'b0;
      w_cap0       = 1'b0;
      w_cap1       = 1'b0;
      w_mul_en     = 1'b0;
      w_out_en     = 1'b0;
      case (r_state)
         ST_IDLE:  w_accept     = tick_i;
         ST_ADDR0: w_load_addr1 = 1'b1;
         ST_CAPT0: w_cap0       = 1'b1;
         ST_CAPT1: w_cap1       = 1'b1;
         ST_MUL:   w_mul_en     = 1'b1;
         ST_OUT:   w_out_en     = 1'b1;
         default:  w_accept     = 1'b0;
      endcase
   end

   // Phase accumulator, ROM address, sample capture and status flags
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         r_phase    <= {PHASE_W{1'b0}};
         r_idx      <= {AWIDTH{1'b0}};
         r_frac     <= {FRAC_W{1'b0}};
         r_rom_addr <= {AWIDTH{1'b0}};
         r_s0       <= {DWIDTH{1'b0}};
         r_s1       <= {DWIDTH{1'b0}};
         r_valid    <= 1'b0;
         r_busy     <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_idx      <= w_lookup_phase[PHASE_W-1 -: AWIDTH];
            r_frac     <= w_lookup_phase[PHASE_W-AWIDTH-1 -: FRAC_W];
            r_rom_addr <= w_lookup_phase[PHASE_W-1 -: AWIDTH];
            r_phase    <= w_lookup_phase + phase_inc_i;
         end else if (phase_rst_i) begin
            r_phase    <= {PHASE_W{1'b0}};
         end else begin
            r_phase    <= r_phase;
         end
         // idx+1 wraps naturally at AWIDTH bits (last entry pairs with entry 0)
         if (w_load_addr1) begin
            r_rom_addr <= r_idx + AWIDTH'(1'b1);
         end
         if (w_cap0) begin
            r_s0 <= rom_rddata_i;
         end
         if (w_cap1) begin
            r_s1 <= rom_rddata_i;
         end
         if (tick_i && (r_state != ST_IDLE)) begin
            r_overrun <= 1'b1;
         end
         r_valid <= w_out_en;
         r_busy  <= (w_next_state != ST_IDLE);
      end
   end

   lfo_interp #(
      .DWIDTH (DWIDTH),
      .FRAC_W (FRAC_W)
   ) u_interp (
      .clk_i    (clk_i),
      .srst_i   (srst_i),
      .mul_en_i (w_mul_en),
      .out_en_i (w_out_en),
      .s0_i     (r_s0),
      .s1_i     (r_s1),
      .frac_i   (r_frac),
      .lfo_o    (w_lfo)
   );

   assign rom_rdaddr_o = r_rom_addr;
   assign lfo_o        = w_lfo;
   assign lfo_valid_o  = r_valid;
   assign busy_o       = r_busy;
   assign overrun_o    = r_overrun;

endmodule

// File: tb/tb_wavetable_reader.sv
// ---------------------------------------------------------------------------
// tb_wavetable_reader
// Self-checking bench: table-driven lookups, hand-written overrun / reset
// sequences, and randomized lookups against an arithmetic reference model.
// ROM model: table[k] = 100*k, registered address, 1-cycle latency.
// ---------------------------------------------------------------------------
module tb_wavetable_reader;

   logic        clk = 1'b0;
   logic        srst;
   logic        tick;
   logic [23:0] phase_inc;
   logic        phase_rst;
   logic [8:0]  rom_rdaddr;
   logic [15:0] rom_rddata;
   logic [15:0] lfo;
   logic        lfo_valid;
   logic        busy;
   logic        overrun;

   logic [8:0]  rom_q_addr = 9'd0;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic [23:0] inc;
      bit          pre_rst;
      bit          co_rst;
      logic [15:0] lfo;
      logic [8:0]  a0;
      logic [8:0]  a1;
   } vec_t;

   vec_t vecs [7];

   wavetable_reader dut (
      .clk_i        (clk),
      .srst_i       (srst),
      .tick_i       (tick),
      .phase_inc_i  (phase_inc),
      .phase_rst_i  (phase_rst),
      .rom_rdaddr_o (rom_rdaddr),
      .rom_rddata_i (rom_rddata),
      .lfo_o        (lfo),
      .lfo_valid_o  (lfo_valid),
      .busy_o       (busy),
      .overrun_o    (overrun)
   );

   always #5 clk = ~clk;

   // ROM: registered address, unregistered data
   always @(posedge clk) rom_q_addr <= rom_rdaddr;
   assign rom_rddata = 16'(32'(rom_q_addr) * 32'd100);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      else
         n_pass++;
   endtask

   // Reference: linear interpolation computed straight from the phase word
   function automatic logic [15:0] model_lfo(input logic [23:0] ph);
      int idx  = int'(ph >> 15);
      int frac = int'((ph >> 7) & 24'hFF);
      int s0   = 100 * idx;
      int s1   = 100 * ((idx + 1) % 512);
      int d    = (s1 - s0) * frac;
      return 16'(s0 + (d >>> 8));
   endfunction

   task automatic do_reset();
      srst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      srst = 1'b0;
   endtask

   task automatic pulse_phase_rst();
      phase_rst = 1'b1;
      @(negedge clk);
      phase_rst = 1'b0;
   endtask

   // Called at a negedge; tick visible for cycle 0, checks through cycle 7
   task automatic run_lookup(input logic [23:0] inc, input bit co,
                             input logic [15:0] exp_lfo,
                             input logic [8:0] a0, input logic [8:0] a1,
                             input string tag);
      tick      = 1'b1;
      phase_inc = inc;
      phase_rst = co;
      @(negedge clk);
      tick      = 1'b0;
      phase_rst = 1'b0;
      phase_inc = 24'($urandom);          // must not matter after the tick
      check({tag, " busy c1"}, 32'(busy), 32'd1);
      check({tag, " addr c1"}, 32'(rom_rdaddr), 32'(a0));
      for (int c = 2; c <= 6; c++) begin
         @(negedge clk);
         if (c == 2) check({tag, " addr c2"}, 32'(rom_rdaddr), 32'(a1));
         if (c < 6) begin
            check({tag, " valid early"}, 32'(lfo_valid), 32'd0);
         end else begin
            check({tag, " valid c6"}, 32'(lfo_valid), 32'd1);
            check({tag, " lfo"}, 32'(lfo), 32'(exp_lfo));
         end
      end
      @(negedge clk);
      check({tag, " valid c7"}, 32'(lfo_valid), 32'd0);
      check({tag, " idle c7"}, 32'(busy), 32'd0);
      check({tag, " lfo held"}, 32'(lfo), 32'(exp_lfo));
   endtask

   initial begin
      int          vcount;
      logic [23:0] mp;
      logic [23:0] lp;
      logic [23:0] rinc;
      bit          co;

      vecs[0] = '{24'h004000, 1'b0, 1'b0, 16'd0,     9'd0,   9'd1};
      vecs[1] = '{24'h004000, 1'b0, 1'b0, 16'd50,    9'd0,   9'd1};
      vecs[2] = '{24'h004000, 1'b0, 1'b0, 16'd100,   9'd1,   9'd2};
      vecs[3] = '{24'hFFC000, 1'b1, 1'b0, 16'd0,     9'd0,   9'd1};
      vecs[4] = '{24'hFFC000, 1'b0, 1'b0, 16'd25550, 9'd511, 9'd0};
      vecs[5] = '{24'h008000, 1'b0, 1'b1, 16'd0,     9'd0,   9'd1};
      vecs[6] = '{24'h008000, 1'b0, 1'b0, 16'd100,   9'd1,   9'd2};

      srst = 1'b1; tick = 1'b0; phase_inc = 24'd0; phase_rst = 1'b0;
      @(negedge clk);
      do_reset();
      check("rst busy",    32'(busy),       32'd0);
      check("rst lfo",     32'(lfo),        32'd0);
      check("rst valid",   32'(lfo_valid),  32'd0);
      check("rst overrun", 32'(overrun),    32'd0);
      check("rst addr",    32'(rom_rdaddr), 32'd0);

      // Table-driven lookups
      for (int i = 0; i < 7; i++) begin
         if (vecs[i].pre_rst) pulse_phase_rst();
         run_lookup(vecs[i].inc, vecs[i].co_rst, vecs[i].lfo, vecs[i].a0, vecs[i].a1,
                    $sformatf("vec%0d", i));
      end
      check("no overrun", 32'(overrun), 32'd0);

      // Overrun: second tick at cycle 3 is ignored
      do_reset();
      tick = 1'b1; phase_inc = 24'h004000;
      vcount = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (lfo_valid) vcount++;
         tick = (c == 3);
         phase_inc = (c == 3) ? 24'h123456 : 24'h000000;
      end
      check("ovr pulses", 32'(vcount), 32'd1);
      check("ovr flag", 32'(overrun), 32'd1);
      run_lookup(24'h000000, 1'b0, 16'd50, 9'd0, 9'd1, "ovr next");
      check("ovr sticky", 32'(overrun), 32'd1);

      // Reset in cycle 3 aborts the lookup
      run_lookup(24'h008000, 1'b0, 16'd50, 9'd0, 9'd1, "pre abort");
      tick = 1'b1; phase_inc = 24'd0;
      @(negedge clk); tick = 1'b0;
      @(negedge clk);
      @(negedge clk); srst = 1'b1;
      @(negedge clk); srst = 1'b0;
      check("abort busy",    32'(busy),      32'd0);
      check("abort lfo",     32'(lfo),       32'd0);
      check("abort overrun", 32'(overrun),   32'd0);
      vcount = 0;
      for (int c = 0; c < 8; c++) begin
         if (lfo_valid) vcount++;
         @(negedge clk);
      end
      check("abort pulses", 32'(vcount), 32'd0);
      check("abort lfo later", 32'(lfo), 32'd0);
      run_lookup(24'h004000, 1'b0, 16'd0, 9'd0, 9'd1, "after abort");

      // Randomized lookups against the reference model
      do_reset();
      mp = 24'd0;
      for (int n = 0; n < 40; n++) begin
         for (int g = $urandom_range(0, 3); g > 0; g--) @(negedge clk);
         if ($urandom_range(0, 7) == 0) begin
            pulse_phase_rst();
            mp = 24'd0;
         end
         co   = ($urandom_range(0, 7) == 0);
         rinc = 24'($urandom);
         lp   = co ? 24'd0 : mp;
         run_lookup(rinc, co, model_lfo(lp), lp[23:15], lp[23:15] + 9'd1,
                    $sformatf("rnd%0d", n));
         mp = lp + rinc;
      end
      check("rnd overrun", 32'(overrun), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
